// File: rtl/test_mailbox_pkg.sv
// Shared constants and types for the test-result mailbox: register map,
// command codes, FSM states and the STATUS register layout.
package test_mailbox_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned WD_W   = 32;

    localparam logic [1:0] OFS_DATA   = 2'd0;
    localparam logic [1:0] OFS_CTRL   = 2'd1;
    localparam logic [1:0] OFS_STATUS = 2'd2;
    localparam logic [1:0] OFS_COUNT  = 2'd3;

    localparam logic [DATA_W-1:0] CMD_END   = 8'hA5;
    localparam logic [DATA_W-1:0] CMD_CLEAR = 8'h5A;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        DONE = 2'd1,
        TOUT = 2'd2
    } mbox_state_t;

    typedef struct packed {
        logic       done;
        logic       pass;
        logic       fail;
        logic       tout;
        logic [3:0] rsvd;
    } mbox_status_t;

    // Signature step: rotate left by one, then fold in the new byte.
    function automatic logic [DATA_W-1:0] sig_fold(input logic [DATA_W-1:0] s,
                                                   input logic [DATA_W-1:0] d);
        return {s[DATA_W-2:0], s[DATA_W-1]} ^ d;
    endfunction

endpackage

// File: rtl/mbox_watchdog.sv
// Saturating cycle counter with enable and clear; expired_o is a registered
// flag that is high while the count sits at LIMIT-1 (never when LIMIT is 0).
module mbox_watchdog
    import test_mailbox_pkg::*;
#(
    parameter logic [WD_W-1:0] LIMIT = 32'd220
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic en_i,
    input  logic clr_i,
    output logic expired_o
);

    localparam logic [WD_W-1:0] LAST  = LIMIT - WD_W'(1);
    localparam logic            ARMED = (LIMIT != '0);

    logic [WD_W-1:0] cnt_q, cnt_d;
    logic            expired_q, expired_d;

    // Clear dominates; the counter stops at all-ones rather than wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + WD_W'(1);
        end
        expired_d = ARMED && (cnt_d == LAST);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q     <= '0;
            expired_q <= ARMED && (LAST == '0);
        end else begin
            cnt_q     <= cnt_d;
            expired_q <= expired_d;
        end
    end

    assign expired_o = expired_q;

endmodule

// File: rtl/test_mailbox.sv
// Memory-mapped test-result mailbox: folds DATA writes into a signature,
// judges it against EXPECT on END, and times out programs that never finish.
module test_mailbox
    import test_mailbox_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE    = 16'h00F0,
    parameter logic [DATA_W-1:0] EXPECT  = 8'h9D,
    parameter logic [WD_W-1:0]   TIMEOUT = 32'd220
) (
    input  logic              ph1,
    input  logic              reset_b,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] wdata,
    input  logic              write_en,
    input  logic              read_en,
    output logic              hit,
    output logic [DATA_W-1:0] rdata,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic [DATA_W-1:0] sig,
    output logic [DATA_W-1:0] count
);

    mbox_state_t       state_q, state_d;
    logic [DATA_W-1:0] sig_q, sig_d;
    logic [DATA_W-1:0] count_q, count_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              fail_q, fail_d;
    logic              tout_q, tout_d;

    logic              wr_data, wr_ctrl, cmd_end, cmd_clear, rd_hit;
    logic              wd_en, wd_clr, wd_expired;
    mbox_status_t      status;

    assign hit       = (address[ADDR_W-1:2] == BASE[ADDR_W-1:2]);
    assign wr_data   = write_en && hit && (address[1:0] == OFS_DATA);
    assign wr_ctrl   = write_en && hit && (address[1:0] == OFS_CTRL);
    assign cmd_end   = wr_ctrl && (wdata == CMD_END);
    assign cmd_clear = wr_ctrl && (wdata == CMD_CLEAR);
    assign rd_hit    = read_en && hit;

    always_comb begin
        status      = '0;
        status.done = done_q;
        status.pass = pass_q;
        status.fail = fail_q;
        status.tout = tout_q;
    end

    mbox_watchdog #(
        .LIMIT(TIMEOUT)
    ) u_wd (
        .clk_i    (ph1),
        .rst_n_i  (reset_b),
        .en_i     (wd_en),
        .clr_i    (wd_clr),
        .expired_o(wd_expired)
    );

    // Next-state, signature and read-mux logic.
    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        count_d = count_q;
        done_d  = done_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        tout_d  = tout_q;
        rdata_d = rdata_q;
        wd_en   = (state_q == RUN);
        wd_clr  = cmd_clear;

        case (state_q)
            RUN: begin
                if (wr_data) begin
                    sig_d   = sig_fold(sig_q, wdata);
                    count_d = (count_q == '1) ? count_q : count_q + DATA_W'(1);
                end
                // END beats a timeout landing on the same edge.
                if (cmd_end) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    pass_d  = (sig_q == EXPECT);
                    fail_d  = (sig_q != EXPECT);
                end else if (wd_expired) begin
                    state_d = TOUT;
                    done_d  = 1'b1;
                    pass_d  = 1'b0;
                    fail_d  = 1'b1;
                    tout_d  = 1'b1;
                end
            end
            DONE, TOUT: begin
                state_d = state_q;
            end
            default: begin
                state_d = RUN;
            end
        endcase

        if (cmd_clear) begin
            state_d = RUN;
            sig_d   = '0;
            count_d = '0;
            done_d  = 1'b0;
            pass_d  = 1'b0;
            fail_d  = 1'b0;
            tout_d  = 1'b0;
        end

        // Reads see the pre-write state even when a write shares the cycle.
        if (rd_hit) begin
            case (address[1:0])
                OFS_DATA:   rdata_d = sig_q;
                OFS_CTRL:   rdata_d = EXPECT;
                OFS_STATUS: rdata_d = status;
                default:    rdata_d = count_q;
            endcase
        end
    end

    always_ff @(posedge ph1 or negedge reset_b) begin
        if (!reset_b) begin
            state_q <= RUN;
            sig_q   <= '0;
            count_q <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            count_q <= count_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            tout_q  <= tout_d;
        end
    end

    assign rdata = rdata_q;
    assign done  = done_q;
    assign pass  = pass_q;
    assign fail  = fail_q;
    assign sig   = sig_q;
    assign count = count_q;

endmodule

// File: tb/tb_test_mailbox.sv
// Self-checking bench for test_mailbox: a table of bus vectors with expected
// outputs, a read-data scoreboard, and hand sequences for multi-cycle cases.
module tb_test_mailbox;

    localparam logic [15:0] BASE = 16'h00F0;

    logic        ph1;
    logic        reset_b;
    logic [15:0] address;
    logic [7:0]  wdata;
    logic        write_en;
    logic        read_en;

    logic        hit, done, pass, fail;
    logic [7:0]  rdata, sig, count;
    logic        hit_nw, done_nw, pass_nw, fail_nw;
    logic [7:0]  rdata_nw, sig_nw, count_nw;

    int total = 0;
    int bad   = 0;
    logic [7:0] rd_sb[$];

    test_mailbox #(.BASE(BASE), .EXPECT(8'h9D), .TIMEOUT(32'd20)) u_dut (
        .ph1(ph1), .reset_b(reset_b), .address(address), .wdata(wdata),
        .write_en(write_en), .read_en(read_en), .hit(hit), .rdata(rdata),
        .done(done), .pass(pass), .fail(fail), .sig(sig), .count(count)
    );

    test_mailbox #(.BASE(BASE), .EXPECT(8'h9D), .TIMEOUT(32'd0)) u_nw (
        .ph1(ph1), .reset_b(reset_b), .address(address), .wdata(wdata),
        .write_en(write_en), .read_en(read_en), .hit(hit_nw), .rdata(rdata_nw),
        .done(done_nw), .pass(pass_nw), .fail(fail_nw), .sig(sig_nw), .count(count_nw)
    );

    initial ph1 = 1'b0;
    always #5 ph1 = ~ph1;

    initial begin
        #200000;
        $display("FAIL sim_timeout: got no finish, want finish");
        $fatal(1);
    end

    typedef struct {
        logic       we;
        logic       re;
        logic [1:0] ofs;
        logic [7:0] wd;
        logic [7:0] e_sig;
        logic [7:0] e_cnt;
        logic [2:0] e_dpf;
        logic [7:0] e_rd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic we, input logic re, input logic [1:0] ofs,
                                input logic [7:0] wd, input logic [7:0] e_sig,
                                input logic [7:0] e_cnt, input logic [2:0] e_dpf,
                                input logic [7:0] e_rd);
        vec_t v;
        v.we = we; v.re = re; v.ofs = ofs; v.wd = wd;
        v.e_sig = e_sig; v.e_cnt = e_cnt; v.e_dpf = e_dpf; v.e_rd = e_rd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // One bus cycle; a read pushes its expected data, popped after the edge.
    task automatic bus(input logic we, input logic re, input logic [15:0] addr,
                       input logic [7:0] wd, input logic [7:0] e_rd, input bit on_nw);
        logic [7:0] exp;
        address  = addr;
        wdata    = wd;
        write_en = we;
        read_en  = re;
        if (re) rd_sb.push_back(e_rd);
        @(posedge ph1);
        #1;
        write_en = 1'b0;
        read_en  = 1'b0;
        address  = 16'h0000;
        if (re) begin
            exp = rd_sb.pop_front();
            chk(on_nw ? "rdata_nw" : "rdata", 32'(on_nw ? rdata_nw : rdata), 32'(exp));
        end
    endtask

    task automatic wr(input logic [1:0] ofs, input logic [7:0] wd);
        bus(1'b1, 1'b0, 16'(BASE + 16'(ofs)), wd, 8'h00, 1'b0);
    endtask

    task automatic rd(input logic [1:0] ofs, input logic [7:0] e_rd, input bit on_nw);
        bus(1'b0, 1'b1, 16'(BASE + 16'(ofs)), 8'h00, e_rd, on_nw);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge ph1);
            #1;
        end
    endtask

    task automatic do_reset();
        @(negedge ph1);
        reset_b = 1'b0;
        #1;
        chk("rst_dpf", 32'({done, pass, fail}), 32'd0);
        chk("rst_sig_cnt", 32'({sig, count}), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        @(negedge ph1);
        reset_b = 1'b1;
    endtask

    task automatic chk_state(input string name, input logic [7:0] e_sig,
                             input logic [7:0] e_cnt, input logic [2:0] e_dpf);
        chk({name, "_sig"}, 32'(sig), 32'(e_sig));
        chk({name, "_cnt"}, 32'(count), 32'(e_cnt));
        chk({name, "_dpf"}, 32'({done, pass, fail}), 32'(e_dpf));
    endtask

    initial begin
        reset_b  = 1'b0;
        address  = 16'h0000;
        wdata    = 8'h00;
        write_en = 1'b0;
        read_en  = 1'b0;

        //       we    re    ofs   wd     sig    cnt    dpf     rdata
        vecs.push_back(mk(1'b1, 1'b0, 2'd0, 8'h9D, 8'h9D, 8'h01, 3'b000, 8'h00));
        vecs.push_back(mk(1'b1, 1'b0, 2'd1, 8'hA5, 8'h9D, 8'h01, 3'b110, 8'h00));
        vecs.push_back(mk(1'b0, 1'b1, 2'd2, 8'h00, 8'h9D, 8'h01, 3'b110, 8'hC0));
        vecs.push_back(mk(1'b0, 1'b1, 2'd0, 8'h00, 8'h9D, 8'h01, 3'b110, 8'h9D));
        vecs.push_back(mk(1'b0, 1'b1, 2'd1, 8'h00, 8'h9D, 8'h01, 3'b110, 8'h9D));
        vecs.push_back(mk(1'b0, 1'b1, 2'd3, 8'h00, 8'h9D, 8'h01, 3'b110, 8'h01));
        vecs.push_back(mk(1'b1, 1'b0, 2'd0, 8'h33, 8'h9D, 8'h01, 3'b110, 8'h00));
        vecs.push_back(mk(1'b1, 1'b0, 2'd1, 8'h5A, 8'h00, 8'h00, 3'b000, 8'h00));
        vecs.push_back(mk(1'b1, 1'b0, 2'd0, 8'h01, 8'h01, 8'h01, 3'b000, 8'h00));
        vecs.push_back(mk(1'b1, 1'b0, 2'd0, 8'h02, 8'h00, 8'h02, 3'b000, 8'h00));
        vecs.push_back(mk(1'b1, 1'b0, 2'd1, 8'hA5, 8'h00, 8'h02, 3'b101, 8'h00));
        vecs.push_back(mk(1'b0, 1'b1, 2'd2, 8'h00, 8'h00, 8'h02, 3'b101, 8'hA0));
        vecs.push_back(mk(1'b1, 1'b0, 2'd1, 8'h5A, 8'h00, 8'h00, 3'b000, 8'h00));
        vecs.push_back(mk(1'b1, 1'b0, 2'd1, 8'h77, 8'h00, 8'h00, 3'b000, 8'h00));
        vecs.push_back(mk(1'b1, 1'b0, 2'd0, 8'h9D, 8'h9D, 8'h01, 3'b000, 8'h00));
        vecs.push_back(mk(1'b1, 1'b0, 2'd2, 8'hFF, 8'h9D, 8'h01, 3'b000, 8'h00));
        vecs.push_back(mk(1'b0, 1'b1, 2'd2, 8'h00, 8'h9D, 8'h01, 3'b000, 8'h00));
        vecs.push_back(mk(1'b1, 1'b1, 2'd0, 8'h00, 8'h3B, 8'h02, 3'b000, 8'h9D));
        vecs.push_back(mk(1'b1, 1'b0, 2'd0, 8'h3B, 8'h4D, 8'h03, 3'b000, 8'h00));
        vecs.push_back(mk(1'b1, 1'b0, 2'd1, 8'hA5, 8'h4D, 8'h03, 3'b101, 8'h00));
        vecs.push_back(mk(1'b0, 1'b1, 2'd0, 8'h00, 8'h4D, 8'h03, 3'b101, 8'h4D));

        do_reset();

        foreach (vecs[i]) begin
            bus(vecs[i].we, vecs[i].re, 16'(BASE + 16'(vecs[i].ofs)), vecs[i].wd,
                vecs[i].e_rd, 1'b0);
            chk($sformatf("v%0d_sig", i), 32'(sig), 32'(vecs[i].e_sig));
            chk($sformatf("v%0d_cnt", i), 32'(count), 32'(vecs[i].e_cnt));
            chk($sformatf("v%0d_dpf", i), 32'({done, pass, fail}), 32'(vecs[i].e_dpf));
        end

        // Watchdog: 20 cycles after CLEAR the test is forced to TOUT.
        wr(2'd1, 8'h5A);
        idle(19);
        chk_state("wd19", 8'h00, 8'h00, 3'b000);
        idle(1);
        chk_state("wd20", 8'h00, 8'h00, 3'b101);
        rd(2'd2, 8'hB0, 1'b0);
        wr(2'd1, 8'hA5);
        chk_state("wd_end", 8'h00, 8'h00, 3'b101);
        rd(2'd2, 8'hB0, 1'b0);
        chk("nw_no_timeout", 32'(done_nw), 32'd1);

        // Recovery from a failed run via CLEAR.
        wr(2'd1, 8'h5A);
        chk_state("clr", 8'h00, 8'h00, 3'b000);
        wr(2'd0, 8'h9D);
        wr(2'd1, 8'hA5);
        chk_state("clr_pass", 8'h9D, 8'h01, 3'b110);

        // END landing on the same edge as the timeout wins.
        wr(2'd1, 8'h5A);
        wr(2'd0, 8'h9D);
        idle(18);
        chk_state("race_pre", 8'h9D, 8'h01, 3'b000);
        wr(2'd1, 8'hA5);
        chk_state("race", 8'h9D, 8'h01, 3'b110);
        rd(2'd2, 8'hC0, 1'b0);

        // Asynchronous reset in the middle of a test.
        wr(2'd1, 8'h5A);
        wr(2'd0, 8'h55);
        rd(2'd0, 8'h55, 1'b0);
        chk_state("pre_rst", 8'h55, 8'h01, 3'b000);
        #2;
        reset_b = 1'b0;
        #1;
        chk("async_dpf", 32'({done, pass, fail}), 32'd0);
        chk("async_sig_cnt", 32'({sig, count}), 32'd0);
        chk("async_rdata", 32'(rdata), 32'd0);
        @(negedge ph1);
        reset_b = 1'b1;
        wr(2'd0, 8'h9D);
        wr(2'd1, 8'hA5);
        chk_state("post_rst", 8'h9D, 8'h01, 3'b110);

        // Count saturation on the instance with the watchdog disabled.
        do_reset();
        for (int i = 0; i < 255; i++) wr(2'd0, 8'h00);
        chk("nw_cnt255", 32'(count_nw), 32'hFF);
        wr(2'd0, 8'h00);
        chk("nw_cnt256", 32'(count_nw), 32'hFF);
        chk("nw_sig", 32'(sig_nw), 32'h00);
        chk("nw_dpf", 32'({done_nw, pass_nw, fail_nw}), 32'd0);
        rd(2'd3, 8'hFF, 1'b1);

        // Address decode boundaries.
        address = 16'(BASE + 16'd3);
        #1;
        chk("hit_base3", 32'(hit_nw), 32'd1);
        address = 16'(BASE + 16'd4);
        #1;
        chk("hit_base4", 32'(hit_nw), 32'd0);
        address = 16'h01F0;
        #1;
        chk("hit_hi", 32'(hit), 32'd0);
        bus(1'b1, 1'b0, 16'(BASE + 16'd5), 8'h5A, 8'h00, 1'b0);
        bus(1'b1, 1'b0, 16'(BASE + 16'd4), 8'h12, 8'h00, 1'b0);
        bus(1'b0, 1'b1, 16'(BASE + 16'd6), 8'h00, 8'hFF, 1'b1);
        chk("miss_cnt", 32'(count_nw), 32'hFF);
        chk("miss_sig", 32'(sig_nw), 32'h00);
        chk("miss_dpf", 32'({done_nw, pass_nw, fail_nw}), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
